if_stage_fetch: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register.
- Produces the 32-bit instruction word that the ID-stage control decoder consumes.
- Owns the PC and the request/ready handshake to instruction memory.
- Handles stalls with a one-entry skid buffer, and branch/jump redirects by injecting the all-zero NOP word (32'd0), which the decoder treats as a bubble.

---
 rtl/if_stage_fetch.sv | 130 +++++++++++++
 tb/tb_if_stage_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory, and drives
// the IF/ID register with a one-entry skid buffer for stalls and NOP bubbles for redirects.
module if_stage_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect_branch,
    input  logic [31:0] branch_target,
    input  logic        redirect_jump,
    input  logic [25:0] jump_index,
    output logic [31:0] instr_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUF  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'd0;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_data;
    logic        req_q;

    logic        redirect;
    logic [31:0] pc_next_seq;
    logic [31:0] target;

    // Low address bits of the branch target are forced to word alignment.
    logic unused_target_bits;
    assign unused_target_bits = &{1'b0, branch_target[1:0]};

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] base);
        return base + 32'd4;
    endfunction

    // The branch is the older instruction, so it takes priority over a jump.
    function automatic logic [31:0] redirect_target(
        input logic        is_branch,
        input logic [31:0] br_target,
        input logic [3:0]  pc4_region,
        input logic [25:0] j_index
    );
        if (is_branch)
            return {br_target[31:2], 2'b00};
        else
            return {pc4_region, j_index, 2'b00};
    endfunction

    assign redirect    = redirect_branch || redirect_jump;
    assign pc_next_seq = pc_inc(pc);
    assign target      = redirect_target(redirect_branch, branch_target,
                                         pc4_id[31:28], jump_index);

    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign fetch_busy = (state == REQ) && !imem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= PC_RESET;
            skid_data <= 32'd0;
            req_q     <= 1'b0;
            instr_id  <= NOP_WORD;
            pc4_id    <= 32'd0;
            valid_id  <= 1'b0;
        end else if (redirect) begin
            // Any word returned this cycle belongs to the wrong path and is dropped.
            state     <= REQ;
            pc        <= target;
            skid_data <= 32'd0;
            req_q     <= 1'b1;
            instr_id  <= NOP_WORD;
            pc4_id    <= 32'd0;
            valid_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (imem_ready && !stall) begin
                        instr_id <= imem_rdata;
                        pc4_id   <= pc_next_seq;
                        valid_id <= 1'b1;
                        pc       <= pc_next_seq;
                    end else if (imem_ready && stall) begin
                        // ID cannot accept the word yet; park it and stop requesting.
                        skid_data <= imem_rdata;
                        state     <= BUF;
                        req_q     <= 1'b0;
                    end else if (!stall) begin
                        instr_id <= NOP_WORD;
                        pc4_id   <= 32'd0;
                        valid_id <= 1'b0;
                    end
                end
                BUF: begin
                    if (!stall) begin
                        instr_id <= skid_data;
                        pc4_id   <= pc_next_seq;
                        valid_id <= 1'b1;
                        pc       <= pc_next_seq;
                        state    <= REQ;
                        req_q    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: sequential fetch, wait states, skid stall,
// branch/jump redirects, branch priority, PC wrap and asynchronous reset.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect_branch;
    logic [31:0] branch_target;
    logic        redirect_jump;
    logic [25:0] jump_index;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic        fetch_busy;

    int passed = 0;
    int total  = 0;

    if_stage_fetch #(.PC_RESET(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .stall(stall),
        .redirect_branch(redirect_branch),
        .branch_target(branch_target),
        .redirect_jump(redirect_jump),
        .jump_index(jump_index),
        .instr_id(instr_id),
        .pc4_id(pc4_id),
        .valid_id(valid_id),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C01_0004;
            32'h0000_0004: return 32'h0022_1820;
            32'h0000_0008: return 32'h2042_0001;
            32'h0000_000C: return 32'hAC03_0008;
            32'h0000_0010: return 32'h1111_0016;
            32'h0000_0040: return 32'h2222_0040;
            32'h1000_0004: return 32'h3333_0004;
            32'hFFFF_FFFC: return 32'h4444_4FFC;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imem_rdata = rom(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_ready = 1'b1;
        stall = 1'b0;
        redirect_branch = 1'b0;
        branch_target = 32'd0;
        redirect_jump = 1'b0;
        jump_index = 26'd0;
        #2;
        chk("rst_instr", instr_id, 32'd0);
        chk("rst_pc4", pc4_id, 32'd0);
        chk("rst_valid", {31'd0, valid_id}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        step;
        step;
        rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);

        // IDLE -> REQ
        step;
        chk("req_on", {31'd0, imem_req}, 32'd1);
        chk("addr0", imem_addr, 32'h0);
        chk("valid_pre", {31'd0, valid_id}, 32'd0);

        // Sequential fetch
        step;
        chk("seq0_instr", instr_id, 32'h8C01_0004);
        chk("seq0_pc4", pc4_id, 32'h4);
        chk("seq0_valid", {31'd0, valid_id}, 32'd1);
        step;
        chk("seq1_instr", instr_id, 32'h0022_1820);
        chk("seq1_pc4", pc4_id, 32'h8);
        chk("seq1_valid", {31'd0, valid_id}, 32'd1);
        chk("seq1_addr", imem_addr, 32'h8);

        // Two wait states at address 8
        imem_ready = 1'b0;
        #1;
        chk("busy_comb", {31'd0, fetch_busy}, 32'd1);
        step;
        chk("wait0_instr", instr_id, 32'd0);
        chk("wait0_valid", {31'd0, valid_id}, 32'd0);
        chk("wait0_pc4", pc4_id, 32'd0);
        chk("wait0_busy", {31'd0, fetch_busy}, 32'd1);
        step;
        chk("wait1_instr", instr_id, 32'd0);
        chk("wait1_valid", {31'd0, valid_id}, 32'd0);
        chk("wait1_addr", imem_addr, 32'h8);
        imem_ready = 1'b1;
        #1;
        chk("busy_off", {31'd0, fetch_busy}, 32'd0);
        step;
        chk("rom8_instr", instr_id, 32'h2042_0001);
        chk("rom8_pc4", pc4_id, 32'hC);

        // Stall with skid buffer at address 12
        stall = 1'b1;
        step;
        chk("buf_hold_instr", instr_id, 32'h2042_0001);
        chk("buf_hold_pc4", pc4_id, 32'hC);
        chk("buf_req", {31'd0, imem_req}, 32'd0);
        chk("buf_addr", imem_addr, 32'hC);
        chk("buf_busy", {31'd0, fetch_busy}, 32'd0);
        step;
        chk("buf_hold2", instr_id, 32'h2042_0001);
        stall = 1'b0;
        step;
        chk("skid_instr", instr_id, 32'hAC03_0008);
        chk("skid_pc4", pc4_id, 32'h10);
        chk("skid_valid", {31'd0, valid_id}, 32'd1);
        chk("skid_addr", imem_addr, 32'h10);
        chk("skid_req", {31'd0, imem_req}, 32'd1);

        // Branch redirect while stalled in BUF
        stall = 1'b1;
        step;
        chk("buf2_req", {31'd0, imem_req}, 32'd0);
        chk("buf2_instr", instr_id, 32'hAC03_0008);
        redirect_branch = 1'b1;
        branch_target = 32'h0000_0040;
        step;
        chk("br_instr", instr_id, 32'd0);
        chk("br_valid", {31'd0, valid_id}, 32'd0);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_req", {31'd0, imem_req}, 32'd1);
        redirect_branch = 1'b0;
        stall = 1'b0;
        step;
        chk("br_tgt_instr", instr_id, 32'h2222_0040);
        chk("br_tgt_pc4", pc4_id, 32'h44);

        // Branch with misaligned target bits, then a jump in its region
        redirect_branch = 1'b1;
        branch_target = 32'h1000_0005;
        step;
        chk("br_align_addr", imem_addr, 32'h1000_0004);
        redirect_branch = 1'b0;
        step;
        chk("pre_j_instr", instr_id, 32'h3333_0004);
        chk("pre_j_pc4", pc4_id, 32'h1000_0008);
        redirect_jump = 1'b1;
        jump_index = 26'h000_0010;
        step;
        chk("j_addr", imem_addr, 32'h1000_0040);
        chk("j_instr", instr_id, 32'd0);
        chk("j_valid", {31'd0, valid_id}, 32'd0);
        chk("j_pc4", pc4_id, 32'd0);

        // Branch and jump together: branch wins
        redirect_branch = 1'b1;
        branch_target = 32'h0000_0080;
        jump_index = 26'h000_0020;
        step;
        chk("both_addr", imem_addr, 32'h80);
        chk("both_valid", {31'd0, valid_id}, 32'd0);
        redirect_jump = 1'b0;

        // PC wrap
        branch_target = 32'hFFFF_FFFC;
        step;
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_branch = 1'b0;
        step;
        chk("wrap_instr", instr_id, 32'h4444_4FFC);
        chk("wrap_pc4", pc4_id, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);
        chk("wrap_valid", {31'd0, valid_id}, 32'd1);

        // Asynchronous reset mid-REQ, between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_instr", instr_id, 32'd0);
        chk("arst_valid", {31'd0, valid_id}, 32'd0);
        chk("arst_pc4", pc4_id, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_busy", {31'd0, fetch_busy}, 32'd0);
        step;
        rst = 1'b0;
        step;
        chk("rerun_req", {31'd0, imem_req}, 32'd1);
        step;
        chk("rerun_instr", instr_id, 32'h8C01_0004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
